// File: rtl/fmmu_mapper_if.sv
// fmmu_mapper_if -- request / segment / completion bundle for fmmu_mapper.
//
// Signals:
//   req_valid, req_ready, req_laddr[31:0], req_len[LEN_W-1:0], req_write
//       logical datagram request (req_write = 1 for a write datagram)
//   seg_valid, seg_ready, seg_paddr[15:0], seg_len[LEN_W-1:0],
//   seg_offset[LEN_W-1:0], seg_idx[3:0]
//       one physical segment per hitting FMMU entry
//   done, done_hits[4:0]
//       single-cycle completion pulse with the number of segments emitted
//
// Modports:
//   master -- request source / segment sink
//   slave  -- the mapper
interface fmmu_mapper_if #(
  parameter int LEN_W = 11
) ();
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_laddr;
  logic [LEN_W-1:0] req_len;
  logic             req_write;

  logic             seg_valid;
  logic             seg_ready;
  logic [15:0]      seg_paddr;
  logic [LEN_W-1:0] seg_len;
  logic [LEN_W-1:0] seg_offset;
  logic [3:0]       seg_idx;

  logic             done;
  logic [4:0]       done_hits;

  modport master (
    output req_valid, req_laddr, req_len, req_write, seg_ready,
    input  req_ready, seg_valid, seg_paddr, seg_len, seg_offset, seg_idx,
           done, done_hits
  );

  modport slave (
    input  req_valid, req_laddr, req_len, req_write, seg_ready,
    output req_ready, seg_valid, seg_paddr, seg_len, seg_offset, seg_idx,
           done, done_hits
  );
endinterface

// File: rtl/fmmu_mapper.sv
// fmmu_mapper -- maps a logical datagram window onto the FMMU table and
// emits one physical segment per entry the window overlaps.
//
// Ports:
//   clk            single clock, rising edge
//   RST            synchronous active-high reset
//   cfg_phys_start per-entry physical start   (16 bits per entry)
//   cfg_log_start  per-entry logical start    (32 bits per entry)
//   cfg_log_len    per-entry logical length   (LEN_W bits per entry)
//   cfg_en         per-entry enable
//   cfg_rd_en      per-entry read permit
//   cfg_wr_en      per-entry write permit
//   bus            fmmu_mapper_if.slave (request, segment and done signals)
//
// Optional feature: define FMMU_DIR_CHECK_EN to qualify hits with the
// entry's read/write permit for the request direction. Without it the
// permit ports are present but ignored.
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | req_ready=1, waiting for a request
// SCAN  | evaluating entry idx_q against the latched request
// EMIT  | seg_valid=1, holding the segment until seg_ready
// DONE  | done pulse with done_hits, then back to IDLE
module fmmu_mapper #(
  parameter int NUM_FMMU = 4,
  parameter int LEN_W    = 11
) (
  input  logic                      clk,
  input  logic                      RST,
  input  logic [16*NUM_FMMU-1:0]    cfg_phys_start,
  input  logic [32*NUM_FMMU-1:0]    cfg_log_start,
  input  logic [LEN_W*NUM_FMMU-1:0] cfg_log_len,
  input  logic [NUM_FMMU-1:0]       cfg_en,
  input  logic [NUM_FMMU-1:0]       cfg_rd_en,
  input  logic [NUM_FMMU-1:0]       cfg_wr_en,
  fmmu_mapper_if.slave              bus
);

  localparam logic [3:0] IDX_LAST = 4'(NUM_FMMU - 1);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_e;

  state_e           state_q;
  logic [3:0]       idx_q;
  logic [4:0]       hits_q;
  logic [31:0]      laddr_q;
  logic [LEN_W-1:0] len_q;
  logic             write_q;
  logic [15:0]      seg_paddr_q;
  logic [LEN_W-1:0] seg_len_q;
  logic [LEN_W-1:0] seg_offset_q;
  logic [3:0]       seg_idx_q;
  logic [4:0]       done_hits_q;

  // Table padded to 16 entries so the 4-bit index never selects past the end.
  logic [15:0]      phys_a [16];
  logic [31:0]      log_a  [16];
  logic [LEN_W-1:0] llen_a [16];
  logic [15:0]      en_v;

  for (genvar g = 0; g < 16; g++) begin : g_pad
    if (g < NUM_FMMU) begin : g_on
      assign phys_a[g] = cfg_phys_start[g*16 +: 16];
      assign log_a[g]  = cfg_log_start[g*32 +: 32];
      assign llen_a[g] = cfg_log_len[g*LEN_W +: LEN_W];
    end else begin : g_off
      assign phys_a[g] = '0;
      assign log_a[g]  = '0;
      assign llen_a[g] = '0;
    end
  end

  assign en_v = 16'(cfg_en);

  logic dir_ok;
`ifdef FMMU_DIR_CHECK_EN
  logic [15:0] rd_v, wr_v;
  assign rd_v   = 16'(cfg_rd_en);
  assign wr_v   = 16'(cfg_wr_en);
  assign dir_ok = write_q ? wr_v[idx_q] : rd_v[idx_q];
`else
  logic unused_dir;
  assign unused_dir = ^{write_q, cfg_rd_en, cfg_wr_en};
  assign dir_ok     = 1'b1;
`endif

  // Window intersection at 33 bits so ends near 2^32 cannot wrap.
  // Zero lengths fall out as misses because hi can never exceed lo.
  logic [32:0]      log_lo, log_hi, req_lo, req_hi, lo, hi;
  logic             hit_d;
  logic [15:0]      seg_paddr_d;
  logic [LEN_W-1:0] seg_len_d;
  logic [LEN_W-1:0] seg_offset_d;

  always_comb begin
    log_lo       = {1'b0, log_a[idx_q]};
    log_hi       = log_lo + 33'(llen_a[idx_q]);
    req_lo       = {1'b0, laddr_q};
    req_hi       = req_lo + 33'(len_q);
    lo           = (req_lo > log_lo) ? req_lo : log_lo;
    hi           = (req_hi < log_hi) ? req_hi : log_hi;
    hit_d        = en_v[idx_q] & (lo < hi) & dir_ok;
    seg_paddr_d  = phys_a[idx_q] + 16'(lo - log_lo);
    seg_len_d    = LEN_W'(hi - lo);
    seg_offset_d = LEN_W'(lo - req_lo);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      hits_q       <= '0;
      laddr_q      <= '0;
      len_q        <= '0;
      write_q      <= 1'b0;
      seg_paddr_q  <= '0;
      seg_len_q    <= '0;
      seg_offset_q <= '0;
      seg_idx_q    <= '0;
      done_hits_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            laddr_q <= bus.req_laddr;
            len_q   <= bus.req_len;
            write_q <= bus.req_write;
            idx_q   <= '0;
            hits_q  <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (hit_d) begin
            seg_paddr_q  <= seg_paddr_d;
            seg_len_q    <= seg_len_d;
            seg_offset_q <= seg_offset_d;
            seg_idx_q    <= idx_q;
            state_q      <= EMIT;
          end else if (idx_q == IDX_LAST) begin
            done_hits_q <= hits_q;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        EMIT: begin
          if (bus.seg_ready) begin
            hits_q <= hits_q + 5'd1;
            if (idx_q == IDX_LAST) begin
              done_hits_q <= hits_q + 5'd1;
              state_q     <= DONE;
            end else begin
              idx_q   <= idx_q + 4'd1;
              state_q <= SCAN;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.seg_valid  = (state_q == EMIT);
  assign bus.done       = (state_q == DONE);
  assign bus.seg_paddr  = seg_paddr_q;
  assign bus.seg_len    = seg_len_q;
  assign bus.seg_offset = seg_offset_q;
  assign bus.seg_idx    = seg_idx_q;
  assign bus.done_hits  = done_hits_q;

endmodule

// File: tb/tb_fmmu_mapper.sv
// tb_fmmu_mapper -- directed bench for fmmu_mapper (NUM_FMMU=4, LEN_W=11).
// Cycle 0 is the cycle in which the request handshake occurs.
module tb_fmmu_mapper;
  localparam int N = 4;
  localparam int LW = 11;

  logic clk = 1'b0;
  logic RST = 1'b1;
  logic [16*N-1:0] cfg_phys_start = '0;
  logic [32*N-1:0] cfg_log_start  = '0;
  logic [LW*N-1:0] cfg_log_len    = '0;
  logic [N-1:0]    cfg_en = '0, cfg_rd_en = '0, cfg_wr_en = '0;

  fmmu_mapper_if #(.LEN_W(LW)) bus ();

  fmmu_mapper #(.NUM_FMMU(N), .LEN_W(LW)) dut (
    .clk(clk), .RST(RST),
    .cfg_phys_start(cfg_phys_start), .cfg_log_start(cfg_log_start),
    .cfg_log_len(cfg_log_len), .cfg_en(cfg_en),
    .cfg_rd_en(cfg_rd_en), .cfg_wr_en(cfg_wr_en),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int          r_nseg, r_first, r_done_cyc;
  bit          r_got_done, r_ready_done;
  logic [4:0]  r_hits;
  logic [15:0] r_paddr [4];
  logic [10:0] r_len   [4];
  logic [10:0] r_off   [4];
  logic [3:0]  r_idx   [4];

  task automatic clear_cfg();
    cfg_phys_start = '0; cfg_log_start = '0; cfg_log_len = '0;
    cfg_en = '0; cfg_rd_en = '0; cfg_wr_en = '0;
  endtask

  task automatic set_entry(input int i, input logic [15:0] ph, input logic [31:0] lg,
                           input logic [10:0] ln, input logic en, input logic rd, input logic wr);
    cfg_phys_start[i*16 +: 16] = ph;
    cfg_log_start[i*32 +: 32]  = lg;
    cfg_log_len[i*LW +: LW]    = ln;
    cfg_en[i] = en; cfg_rd_en[i] = rd; cfg_wr_en[i] = wr;
  endtask

  // Handshake in cycle 0; returns #1 into cycle 1.
  task automatic start_req(input logic [31:0] la, input logic [10:0] ln, input logic wr);
    @(negedge clk);
    bus.req_laddr = la; bus.req_len = ln; bus.req_write = wr; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // Records transferred segments and the done pulse; returns at the negedge of the done cycle.
  task automatic collect(input int cyc0);
    int cyc = cyc0;
    r_nseg = 0; r_first = -1; r_done_cyc = -1; r_got_done = 1'b0; r_hits = 'x; r_ready_done = 1'bx;
    while (!r_got_done && cyc < cyc0 + 60) begin
      @(negedge clk);
      if (bus.seg_valid && bus.seg_ready) begin
        if (r_first < 0) r_first = cyc;
        if (r_nseg < 4) begin
          r_paddr[r_nseg] = bus.seg_paddr; r_len[r_nseg] = bus.seg_len;
          r_off[r_nseg] = bus.seg_offset; r_idx[r_nseg] = bus.seg_idx;
        end
        r_nseg++;
      end
      if (bus.done) begin
        r_got_done = 1'b1; r_done_cyc = cyc; r_hits = bus.done_hits; r_ready_done = bus.req_ready;
      end else begin
        @(posedge clk);
        #1 cyc++;
      end
    end
  endtask

  task automatic run_req(input logic [31:0] la, input logic [10:0] ln, input logic wr);
    start_req(la, ln, wr);
    collect(1);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", bus.req_ready); end
    checks++; if (bus.seg_valid !== 1'b0) begin errors++; $display("FAIL rst_seg_valid got=%b exp=0", bus.seg_valid); end
    checks++; if (bus.seg_paddr !== 16'h0) begin errors++; $display("FAIL rst_paddr got=%h exp=0", bus.seg_paddr); end
    checks++; if (bus.seg_len !== 11'd0) begin errors++; $display("FAIL rst_len got=%0d exp=0", bus.seg_len); end
    checks++; if (bus.seg_offset !== 11'd0) begin errors++; $display("FAIL rst_offset got=%0d exp=0", bus.seg_offset); end
    checks++; if (bus.seg_idx !== 4'd0) begin errors++; $display("FAIL rst_idx got=%0d exp=0", bus.seg_idx); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", bus.done); end
    checks++; if (bus.done_hits !== 5'd0) begin errors++; $display("FAIL rst_done_hits got=%0d exp=0", bus.done_hits); end
    RST = 1'b0;
  endtask

  task automatic test_containment();
    clear_cfg();
    set_entry(0, 16'h0F00, 32'h1000, 11'd16, 1'b1, 1'b1, 1'b1);
    bus.seg_ready = 1'b1;
    run_req(32'h1004, 11'd4, 1'b0);
    checks++; if (!r_got_done) begin errors++; $display("FAIL cont_done_seen got=timeout exp=done"); end
    checks++; if (r_nseg !== 1) begin errors++; $display("FAIL cont_nseg got=%0d exp=1", r_nseg); end
    checks++; if (r_paddr[0] !== 16'h0F04 || r_len[0] !== 11'd4 || r_off[0] !== 11'd0 || r_idx[0] !== 4'd0)
      begin errors++; $display("FAIL cont_seg got=%h/%0d/%0d/%0d exp=0f04/4/0/0", r_paddr[0], r_len[0], r_off[0], r_idx[0]); end
    checks++; if (r_first !== 2) begin errors++; $display("FAIL cont_first_cycle got=%0d exp=2", r_first); end
    checks++; if (r_done_cyc !== 6) begin errors++; $display("FAIL cont_done_cycle got=%0d exp=6", r_done_cyc); end
    checks++; if (r_hits !== 5'd1) begin errors++; $display("FAIL cont_done_hits got=%0d exp=1", r_hits); end
    checks++; if (r_ready_done !== 1'b0) begin errors++; $display("FAIL cont_ready_in_done got=%b exp=0", r_ready_done); end
    @(posedge clk);
    #1;
    checks++; if (bus.done !== 1'b0 || bus.req_ready !== 1'b1)
      begin errors++; $display("FAIL cont_after_done got=done%b/ready%b exp=done0/ready1", bus.done, bus.req_ready); end
  endtask

  task automatic test_straddle();
    clear_cfg();
    set_entry(0, 16'h0F00, 32'h1000, 11'd8, 1'b1, 1'b1, 1'b1);
    set_entry(1, 16'h0E00, 32'h2000, 11'd8, 1'b1, 1'b1, 1'b1);
    bus.seg_ready = 1'b1;
    run_req(32'h0FFC, 11'd8, 1'b0);
    checks++; if (r_nseg !== 1) begin errors++; $display("FAIL head_nseg got=%0d exp=1", r_nseg); end
    checks++; if (r_paddr[0] !== 16'h0F00 || r_len[0] !== 11'd4 || r_off[0] !== 11'd4 || r_idx[0] !== 4'd0)
      begin errors++; $display("FAIL head_seg got=%h/%0d/%0d/%0d exp=0f00/4/4/0", r_paddr[0], r_len[0], r_off[0], r_idx[0]); end
    checks++; if (r_hits !== 5'd1) begin errors++; $display("FAIL head_done_hits got=%0d exp=1", r_hits); end
    run_req(32'h2004, 11'd16, 1'b0);
    checks++; if (r_nseg !== 1) begin errors++; $display("FAIL tail_nseg got=%0d exp=1", r_nseg); end
    checks++; if (r_paddr[0] !== 16'h0E04 || r_len[0] !== 11'd4 || r_off[0] !== 11'd0 || r_idx[0] !== 4'd1)
      begin errors++; $display("FAIL tail_seg got=%h/%0d/%0d/%0d exp=0e04/4/0/1", r_paddr[0], r_len[0], r_off[0], r_idx[0]); end
    checks++; if (r_first !== 3) begin errors++; $display("FAIL tail_first_cycle got=%0d exp=3", r_first); end
  endtask

  task automatic test_back_to_back_backpressure();
    int cyc;
    bit seen;
    clear_cfg();
    set_entry(0, 16'h0100, 32'h3000, 11'd16, 1'b1, 1'b1, 1'b1);
    set_entry(1, 16'h0700, 32'h5000, 11'd4,  1'b1, 1'b1, 1'b1);
    set_entry(2, 16'h0200, 32'h3008, 11'd16, 1'b1, 1'b1, 1'b1);
    bus.seg_ready = 1'b0;
    start_req(32'h3000, 11'd32, 1'b0);
    cyc = 1; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      if (bus.seg_valid === 1'b1) seen = 1'b1;
      else begin @(posedge clk); #1 cyc++; end
    end
    checks++; if (!seen || cyc !== 2) begin errors++; $display("FAIL bp_first_valid got=seen%0d/cyc%0d exp=seen1/cyc2", seen, cyc); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.seg_valid !== 1'b1 || bus.seg_paddr !== 16'h0100 || bus.seg_len !== 11'd16 ||
          bus.seg_offset !== 11'd0 || bus.seg_idx !== 4'd0)
        begin errors++; $display("FAIL bp_hold%0d got=v%b %h/%0d/%0d/%0d exp=v1 0100/16/0/0", k, bus.seg_valid,
                                 bus.seg_paddr, bus.seg_len, bus.seg_offset, bus.seg_idx); end
      @(negedge clk);
    end
    checks++; if (bus.seg_valid !== 1'b1 || bus.seg_idx !== 4'd0)
      begin errors++; $display("FAIL bp_hold_release got=v%b idx%0d exp=v1 idx0", bus.seg_valid, bus.seg_idx); end
    bus.seg_ready = 1'b1;
    @(posedge clk);
    #1;
    collect(6);
    checks++; if (r_nseg !== 1) begin errors++; $display("FAIL bp_second_nseg got=%0d exp=1", r_nseg); end
    checks++; if (r_paddr[0] !== 16'h0200 || r_len[0] !== 11'd16 || r_off[0] !== 11'd8 || r_idx[0] !== 4'd2)
      begin errors++; $display("FAIL bp_second_seg got=%h/%0d/%0d/%0d exp=0200/16/8/2", r_paddr[0], r_len[0], r_off[0], r_idx[0]); end
    checks++; if (r_hits !== 5'd2) begin errors++; $display("FAIL bp_done_hits got=%0d exp=2", r_hits); end
    checks++; if (r_done_cyc !== 10) begin errors++; $display("FAIL bp_done_cycle got=%0d exp=10", r_done_cyc); end
  endtask

  task automatic test_no_hit();
    clear_cfg();
    set_entry(0, 16'h0F00, 32'h1000, 11'd16, 1'b1, 1'b1, 1'b1);
    set_entry(1, 16'h0E00, 32'h2000, 11'd0,  1'b1, 1'b1, 1'b1);
    set_entry(2, 16'h0D00, 32'h9000, 11'd16, 1'b0, 1'b1, 1'b1);
    bus.seg_ready = 1'b1;
    run_req(32'h9000, 11'd4, 1'b0);
    checks++; if (r_nseg !== 0) begin errors++; $display("FAIL miss_nseg got=%0d exp=0", r_nseg); end
    checks++; if (r_done_cyc !== N + 1) begin errors++; $display("FAIL miss_done_cycle got=%0d exp=%0d", r_done_cyc, N + 1); end
    checks++; if (r_hits !== 5'd0) begin errors++; $display("FAIL miss_done_hits got=%0d exp=0", r_hits); end
    run_req(32'h1004, 11'd0, 1'b0);
    checks++; if (r_nseg !== 0) begin errors++; $display("FAIL zlen_nseg got=%0d exp=0", r_nseg); end
    checks++; if (r_done_cyc !== N + 1) begin errors++; $display("FAIL zlen_done_cycle got=%0d exp=%0d", r_done_cyc, N + 1); end
    run_req(32'h2000, 11'd4, 1'b0);
    checks++; if (r_nseg !== 0 || r_hits !== 5'd0)
      begin errors++; $display("FAIL zloglen got=nseg%0d/hits%0d exp=nseg0/hits0", r_nseg, r_hits); end
  endtask

  task automatic test_direction();
    int exp_w;
`ifdef FMMU_DIR_CHECK_EN
    exp_w = 0;
`else
    exp_w = 1;
`endif
    clear_cfg();
    set_entry(0, 16'h0F00, 32'h1000, 11'd16, 1'b1, 1'b1, 1'b0);
    bus.seg_ready = 1'b1;
    run_req(32'h1004, 11'd4, 1'b1);
    checks++; if (r_nseg !== exp_w) begin errors++; $display("FAIL dir_write_nseg got=%0d exp=%0d", r_nseg, exp_w); end
    run_req(32'h1004, 11'd4, 1'b0);
    checks++; if (r_nseg !== 1 || r_paddr[0] !== 16'h0F04)
      begin errors++; $display("FAIL dir_read got=nseg%0d/%h exp=nseg1/0f04", r_nseg, r_paddr[0]); end
  endtask

  task automatic test_reset_emit_wrap();
    clear_cfg();
    set_entry(0, 16'hFFFE, 32'h4000, 11'd16, 1'b1, 1'b1, 1'b1);
    bus.seg_ready = 1'b0;
    start_req(32'h4004, 11'd4, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.seg_valid !== 1'b1 || bus.seg_paddr !== 16'h0002 || bus.seg_len !== 11'd4 || bus.seg_offset !== 11'd0)
      begin errors++; $display("FAIL wrap_seg got=v%b %h/%0d/%0d exp=v1 0002/4/0", bus.seg_valid, bus.seg_paddr, bus.seg_len, bus.seg_offset); end
    RST = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.seg_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.done !== 1'b0)
      begin errors++; $display("FAIL rst_emit got=v%b r%b d%b exp=v0 r1 d0", bus.seg_valid, bus.req_ready, bus.done); end
    RST = 1'b0;
    bus.seg_ready = 1'b1;
    set_entry(0, 16'h0F00, 32'h1000, 11'd16, 1'b1, 1'b1, 1'b1);
    run_req(32'h1004, 11'd4, 1'b0);
    checks++; if (r_nseg !== 1 || r_paddr[0] !== 16'h0F04 || r_hits !== 5'd1 || r_done_cyc !== 6)
      begin errors++; $display("FAIL post_rst_req got=nseg%0d %h hits%0d cyc%0d exp=nseg1 0f04 hits1 cyc6",
                               r_nseg, r_paddr[0], r_hits, r_done_cyc); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_laddr = '0; bus.req_len = '0; bus.req_write = 1'b0; bus.seg_ready = 1'b0;
    test_reset();
    test_containment();
    test_straddle();
    test_back_to_back_backpressure();
    test_no_hit();
    test_direction();
    test_reset_emit_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
